// File: rtl/ls165_sampled.sv
// LS165 parallel-in/serial-out shift register emulated on the system clock; pin edges are detected from sampled levels.
// Optional macro LS165_PINSYNC_EN adds SYNC_STAGES synchroniser flops on every pin ahead of the sample register.
module ls165_sampled #(
  parameter int CHIPS       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clk_in_i,
  input  logic                 clk_inh_i,
  input  logic                 sh_ld_i,
  input  logic                 ser_i,
  input  logic [8*CHIPS-1:0]   d_i,
  output logic                 qh_o,
  output logic                 qh_n_o,
  output logic                 shift_stb_o,
  output logic                 load_act_o
);

  localparam int W  = 8 * CHIPS;
  localparam int PW = W + 4;

`ifdef LS165_PINSYNC_EN
  localparam int SYNC_EN = 1;
`else
  localparam int SYNC_EN = 0;
`endif
  localparam int SYNC_DEPTH = SYNC_EN * SYNC_STAGES;

  localparam int P_CLK  = W + 3;
  localparam int P_INH  = W + 2;
  localparam int P_SHLD = W + 1;
  localparam int P_SER  = W;

  // Pin flops reset to CLK_IN=1 and SH_LD=1 so that reset release never looks like a clock edge or a load.
  localparam logic [PW-1:0] PIN_RST = {1'b1, 1'b0, 1'b1, 1'b0, {W{1'b0}}};

  logic [PW-1:0] pins_raw;
  logic [PW-1:0] pins_sync;
  logic [PW-1:0] pins_q;

  assign pins_raw = {clk_in_i, clk_inh_i, sh_ld_i, ser_i, d_i};

  generate
    if (SYNC_DEPTH > 0) begin : g_sync
      logic [SYNC_DEPTH-1:0][PW-1:0] sync_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int i = 0; i < SYNC_DEPTH; i++) sync_q[i] <= PIN_RST;
        end else begin
          for (int i = SYNC_DEPTH - 1; i > 0; i--) sync_q[i] <= sync_q[i-1];
          sync_q[0] <= pins_raw;
        end
      end

      assign pins_sync = sync_q[SYNC_DEPTH-1];
    end else begin : g_nosync
      assign pins_sync = pins_raw;
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pins_q <= PIN_RST;
    else       pins_q <= pins_sync;
  end

  logic         s_clk_in;
  logic         s_clk_inh;
  logic         s_sh_ld;
  logic         s_ser;
  logic [W-1:0] s_d;

  assign s_clk_in  = pins_q[P_CLK];
  assign s_clk_inh = pins_q[P_INH];
  assign s_sh_ld   = pins_q[P_SHLD];
  assign s_ser     = pins_q[P_SER];
  assign s_d       = pins_q[W-1:0];

  logic         eff;
  logic         edge_det;
  logic         eff_prev_q;
  logic [W-1:0] shreg_q,     shreg_d;
  logic         shift_stb_q, shift_stb_d;
  logic         load_act_q,  load_act_d;

  // The device gates its clock with an OR, so CLK_INH rising while CLK_IN is low is a real edge.
  assign eff      = s_clk_in | s_clk_inh;
  assign edge_det = eff & ~eff_prev_q;

  always_comb begin
    shreg_d     = shreg_q;
    shift_stb_d = 1'b0;
    load_act_d  = ~s_sh_ld;
    if (!s_sh_ld) begin
      shreg_d = s_d;
    end else if (edge_det) begin
      shreg_d     = {shreg_q[W-2:0], s_ser};
      shift_stb_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      eff_prev_q  <= 1'b1;
      shreg_q     <= '0;
      shift_stb_q <= 1'b0;
      load_act_q  <= 1'b0;
    end else begin
      eff_prev_q  <= eff;
      shreg_q     <= shreg_d;
      shift_stb_q <= shift_stb_d;
      load_act_q  <= load_act_d;
    end
  end

  assign qh_o        = shreg_q[W-1];
  assign qh_n_o      = ~shreg_q[W-1];
  assign shift_stb_o = shift_stb_q;
  assign load_act_o  = load_act_q;

endmodule

// File: tb/tb_ls165_sampled.sv
// Directed bench for ls165_sampled: one-chip and two-chip instances share the control pins; expectations queued per step.
module tb_ls165_sampled;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_in, clk_inh, sh_ld, ser;
  logic [7:0]  d;
  logic [15:0] d2;
  logic        qh, qh_n, stb, la;
  logic        qh2, qh_n2, stb2, la2;

  int n_checks = 0;
  int n_err    = 0;
  int stb_cnt  = 0;

  typedef struct {
    string tag;
    logic  qh;
    logic  stb;
    logic  la;
    logic  qh2;
    logic  chk2;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  ls165_sampled #(.CHIPS(1)) dut (
    .clk_i(clk), .rst_i(rst), .clk_in_i(clk_in), .clk_inh_i(clk_inh),
    .sh_ld_i(sh_ld), .ser_i(ser), .d_i(d),
    .qh_o(qh), .qh_n_o(qh_n), .shift_stb_o(stb), .load_act_o(la)
  );

  ls165_sampled #(.CHIPS(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .clk_in_i(clk_in), .clk_inh_i(clk_inh),
    .sh_ld_i(sh_ld), .ser_i(ser), .d_i(d2),
    .qh_o(qh2), .qh_n_o(qh_n2), .shift_stb_o(stb2), .load_act_o(la2)
  );

  always @(negedge clk) if (!rst && stb) stb_cnt++;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive pins, queue the expected outputs, let the sample and update edges pass, then compare.
  task automatic step(input logic cin, input logic inh, input logic shld, input logic sr,
                      input logic [7:0] dv, input logic [15:0] d2v,
                      input logic eqh, input logic estb, input logic ela,
                      input logic eqh2, input logic c2, input string tag);
    exp_t e;
    @(negedge clk);
    clk_in = cin; clk_inh = inh; sh_ld = shld; ser = sr; d = dv; d2 = d2v;
    sb_q.push_back('{tag, eqh, estb, ela, eqh2, c2});
    @(posedge clk);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 16'd0, 16'd1);
    end else begin
      e = sb_q.pop_front();
      check({e.tag, "_qh"},   {15'd0, qh},   {15'd0, e.qh});
      check({e.tag, "_qhn"},  {15'd0, qh_n}, {15'd0, ~e.qh});
      check({e.tag, "_stb"},  {15'd0, stb},  {15'd0, e.stb});
      check({e.tag, "_la"},   {15'd0, la},   {15'd0, e.la});
      check({e.tag, "_stb2"}, {15'd0, stb2}, {15'd0, e.stb});
      check({e.tag, "_la2"},  {15'd0, la2},  {15'd0, e.la});
      if (e.chk2) begin
        check({e.tag, "_qh2"},  {15'd0, qh2},   {15'd0, e.qh2});
        check({e.tag, "_qhn2"}, {15'd0, qh_n2}, {15'd0, ~e.qh2});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  pat;
    logic [7:0]  pat_f;
    logic [15:0] p2;
    int          snap;
    logic        e1, e2;

    pat   = 8'hA5;
    pat_f = 8'h0F;
    p2    = 16'h8001;

    // Reset with CLK_IN high, then hold CLK_IN high after release: no shift.
    rst = 1'b1; clk_in = 1'b1; clk_inh = 1'b0; sh_ld = 1'b1; ser = 1'b0; d = 8'hA5; d2 = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_qh",  {15'd0, qh},   16'd0);
    check("rst_qhn", {15'd0, qh_n}, 16'd1);
    check("rst_stb", {15'd0, stb},  16'd0);
    check("rst_la",  {15'd0, la},   16'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 8'hA5, 16'hFFFF, 0, 0, 0, 0, 1, "post_rst_hold");
    check("post_rst_stbcnt", stb_cnt[15:0], 16'd0);

    // Load 0xA5 then shift out 8 bits with SER=0.
    snap = stb_cnt;
    step(0, 0, 0, 0, 8'hA5, 16'h0000, 1, 0, 1, 0, 0, "ld_a5");
    step(0, 0, 1, 0, 8'h00, 16'h0000, 1, 0, 0, 0, 0, "ld_a5_rel");
    for (int s = 1; s <= 8; s++) begin
      e1 = (s < 8) ? pat[7-s] : 1'b0;
      step(1, 0, 1, 0, 8'h00, 16'h0000, e1, 1, 0, 0, 0, "shift_a5_rise");
      step(0, 0, 1, 0, 8'h00, 16'h0000, e1, 0, 0, 0, 0, "shift_a5_fall");
    end
    check("shift_a5_stbcnt", 16'(stb_cnt - snap), 16'd8);

    // Clock inhibit: pulses masked, INH falling while CLK_IN low is not an edge, INH rising is.
    snap = stb_cnt;
    step(0, 1, 0, 0, 8'hA5, 16'h0000, 1, 0, 1, 0, 0, "inh_ld");
    step(0, 1, 1, 0, 8'h00, 16'h0000, 1, 0, 0, 0, 0, "inh_rel");
    for (int p = 0; p < 4; p++) begin
      step(1, 1, 1, 0, 8'h00, 16'h0000, 1, 0, 0, 0, 0, "inh_pulse_hi");
      step(0, 1, 1, 0, 8'h00, 16'h0000, 1, 0, 0, 0, 0, "inh_pulse_lo");
    end
    step(0, 0, 1, 0, 8'h00, 16'h0000, 1, 0, 0, 0, 0, "inh_fall");
    check("inh_stbcnt", 16'(stb_cnt - snap), 16'd0);
    step(0, 1, 1, 0, 8'h00, 16'h0000, pat[6], 1, 0, 0, 0, "inh_rise_edge");
    step(0, 0, 1, 0, 8'h00, 16'h0000, pat[6], 0, 0, 0, 0, "inh_rise_done");

    // Transparent load with CLK_IN toggling: QH follows D[7], no shift strobes.
    snap = stb_cnt;
    step(1, 0, 0, 0, 8'h80, 16'h0000, 1, 0, 1, 0, 0, "tload_80");
    step(0, 0, 0, 0, 8'h00, 16'h0000, 0, 0, 1, 0, 0, "tload_00");
    step(1, 0, 0, 0, 8'h80, 16'h0000, 1, 0, 1, 0, 0, "tload_80b");
    for (int i = 0; i < 16; i++) begin
      step(i[0], 0, 0, 0, 8'(i), 16'h0000, 0, 0, 1, 0, 0, "tload_step");
    end
    check("tload_stbcnt", 16'(stb_cnt - snap), 16'd0);
    step(0, 0, 1, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 0, "tload_rel");
    for (int s = 1; s <= 7; s++) begin
      step(1, 0, 1, 0, 8'h00, 16'h0000, pat_f[7-s], 1, 0, 0, 0, "tload_sh_rise");
      step(0, 0, 1, 0, 8'h00, 16'h0000, pat_f[7-s], 0, 0, 0, 0, "tload_sh_fall");
    end

    // Two-chip cascade: load 0x8001, SER=1, 18 edges.
    snap = stb_cnt;
    step(0, 0, 0, 1, 8'h00, 16'h8001, 0, 0, 1, 1, 1, "casc_ld");
    step(0, 0, 1, 1, 8'h00, 16'h0000, 0, 0, 0, 1, 1, "casc_rel");
    for (int s = 1; s <= 18; s++) begin
      e1 = (s >= 8);
      e2 = (s < 16) ? p2[15-s] : 1'b1;
      step(1, 0, 1, 1, 8'h00, 16'h0000, e1, 1, 0, e2, 1, "casc_rise");
      step(0, 0, 1, 1, 8'h00, 16'h0000, e1, 0, 0, e2, 1, "casc_fall");
    end
    check("casc_stbcnt", 16'(stb_cnt - snap), 16'd18);

    // Cycle-accurate latency of a single edge, then reset in the middle of shifting.
    step(0, 0, 0, 1, 8'hFF, 16'hFFFF, 1, 0, 1, 1, 1, "lat_ld");
    step(0, 0, 1, 1, 8'h00, 16'h0000, 1, 0, 0, 1, 1, "lat_rel");
    @(negedge clk);
    clk_in = 1'b1;
    @(posedge clk); #1;
    check("lat_edge_p1", {15'd0, stb}, 16'd0);
    @(posedge clk); #1;
    check("lat_edge_p2", {15'd0, stb}, 16'd1);
    @(posedge clk); #1;
    check("lat_edge_p3", {15'd0, stb}, 16'd0);
    step(0, 0, 1, 1, 8'h00, 16'h0000, 1, 0, 0, 1, 1, "mid_fall1");
    step(1, 0, 1, 1, 8'h00, 16'h0000, 1, 1, 0, 1, 1, "mid_rise2");
    step(0, 0, 1, 1, 8'h00, 16'h0000, 1, 0, 0, 1, 1, "mid_fall2");
    @(negedge clk);
    clk_in = 1'b1;
    @(posedge clk); #1;
    check("mid_pre_rst_qh", {15'd0, qh}, 16'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_qh",  {15'd0, qh},   16'd0);
    check("mid_rst_qhn", {15'd0, qh_n}, 16'd1);
    check("mid_rst_stb", {15'd0, stb},  16'd0);
    check("mid_rst_qh2", {15'd0, qh2},  16'd0);
    @(negedge clk);
    rst = 1'b0;
    snap = stb_cnt;
    step(1, 0, 1, 1, 8'h00, 16'h0000, 0, 0, 0, 0, 1, "post_mid_rst1");
    step(1, 0, 1, 1, 8'h00, 16'h0000, 0, 0, 0, 0, 1, "post_mid_rst2");
    check("post_mid_rst_stbcnt", 16'(stb_cnt - snap), 16'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
